// File: rtl/two_ask_demod.sv
// Non-coherent 2ASK demodulator: counts carrier rising edges over fixed symbol
// windows aligned to the first edge after idle, one decision per window.
module two_ask_demod #(
    parameter int SYM_LEN   = 16,
    parameter int THRESH    = 2,
    parameter int MAX_ZEROS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic y,
    output logic bit_out,
    output logic bit_valid,
    output logic in_frame,
    output logic carrier_lost
);
    typedef enum logic {IDLE, TRACK} state_t;

    localparam logic [7:0] SYM_LAST = 8'(SYM_LEN - 1);
    localparam logic [8:0] THR      = 9'(THRESH);
    localparam logic [8:0] ZMAX     = 9'(MAX_ZEROS);

    state_t     state_q, state_d;
    logic       y_q, y_q2;
    logic [7:0] sym_cnt_q, sym_cnt_d;
    logic [7:0] edge_cnt_q, edge_cnt_d;
    logic [7:0] zero_run_q, zero_run_d;
    logic       bit_out_q, bit_out_d;
    logic       bit_valid_q, bit_valid_d;
    logic       carrier_lost_q, carrier_lost_d;

    logic       rise;
    logic       last;
    logic [8:0] edge_sum;
    logic       dec;
    logic       zero_hit;

    assign rise     = y_q & ~y_q2;
    assign last     = (sym_cnt_q == SYM_LAST);
    // The current cycle's edge still belongs to the closing window.
    assign edge_sum = {1'b0, edge_cnt_q} + {8'd0, rise};
    assign dec      = (edge_sum >= THR);
    assign zero_hit = !dec && (({1'b0, zero_run_q} + 9'd1) == ZMAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            y_q            <= 1'b0;
            y_q2           <= 1'b0;
            sym_cnt_q      <= 8'd0;
            edge_cnt_q     <= 8'd0;
            zero_run_q     <= 8'd0;
            bit_out_q      <= 1'b0;
            bit_valid_q    <= 1'b0;
            carrier_lost_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            y_q            <= y;
            y_q2           <= y_q;
            sym_cnt_q      <= sym_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            zero_run_q     <= zero_run_d;
            bit_out_q      <= bit_out_d;
            bit_valid_q    <= bit_valid_d;
            carrier_lost_q <= carrier_lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = TRACK;
            TRACK:   if (last && zero_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sym_cnt_d      = sym_cnt_q;
        edge_cnt_d     = edge_cnt_q;
        zero_run_d     = zero_run_q;
        bit_out_d      = bit_out_q;
        bit_valid_d    = 1'b0;
        carrier_lost_d = 1'b0;
        case (state_q)
            IDLE: begin
                sym_cnt_d  = 8'd0;
                edge_cnt_d = 8'd0;
                zero_run_d = 8'd0;
                if (rise) begin
                    sym_cnt_d  = 8'd1;
                    edge_cnt_d = 8'd1;
                end
            end
            TRACK: begin
                if (last) begin
                    sym_cnt_d   = 8'd0;
                    edge_cnt_d  = 8'd0;
                    bit_out_d   = dec;
                    bit_valid_d = 1'b1;
                    if (dec) begin
                        zero_run_d = 8'd0;
                    end else if (zero_hit) begin
                        zero_run_d     = 8'd0;
                        carrier_lost_d = 1'b1;
                    end else begin
                        zero_run_d = zero_run_q + 8'd1;
                    end
                end else begin
                    sym_cnt_d  = sym_cnt_q + 8'd1;
                    edge_cnt_d = (edge_cnt_q == 8'hFF) ? edge_cnt_q
                                                       : edge_cnt_q + {7'd0, rise};
                end
            end
            default: ;
        endcase
    end

    assign bit_out      = bit_out_q;
    assign bit_valid    = bit_valid_q;
    assign in_frame     = (state_q == TRACK);
    assign carrier_lost = carrier_lost_q;

endmodule

// File: tb/tb_two_ask_demod.sv
// Bench for two_ask_demod: window-level reference model over whole y streams,
// a table of per-window edge counts, and directed loss / async-reset sequences.
module tb_two_ask_demod;
  localparam int L    = 16;
  localparam int TH   = 2;
  localparam int MZ   = 4;
  localparam int MAXN = 1024;

  logic clk, reset, y;
  logic bit_out, bit_valid, in_frame, carrier_lost;

  int checks = 0;
  int errors = 0;

  // ys[k] is captured by y_q at edge k; interval k is the cycle after edge k.
  logic ys  [MAXN];
  logic ev  [MAXN];
  logic ebit[MAXN];
  logic eb  [MAXN];
  logic ef  [MAXN];
  logic el  [MAXN];
  logic ov  [MAXN];
  logic ob  [MAXN];
  logic of_ [MAXN];
  logic ol  [MAXN];

  typedef struct {
    int   nrise;
    logic exp_bit;
  } win_t;
  win_t tbl[8];

  two_ask_demod #(.SYM_LEN(L), .THRESH(TH), .MAX_ZEROS(MZ)) dut (
    .clk(clk), .reset(reset), .y(y),
    .bit_out(bit_out), .bit_valid(bit_valid),
    .in_frame(in_frame), .carrier_lost(carrier_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string nm, input int idx,
                     input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s[%0d] got %b want %b", tag, nm, idx, act, exp);
    end
  endtask

  function automatic logic rs(input int k);
    return ys[k] && ((k == 0) ? 1'b1 : !ys[k-1]);
  endfunction

  task automatic clear_ys();
    for (int i = 0; i < MAXN; i++) ys[i] = 1'b0;
  endtask

  task automatic put_pulses(input int s, input int cnt);
    for (int p = 0; p < cnt; p++) begin
      ys[s + 4*p]     = 1'b1;
      ys[s + 4*p + 1] = 1'b1;
    end
  endtask

  // Window-level model: find a rise, cut fixed windows, count edges per window.
  task automatic model(input int n);
    int k, t0, s, cnt, zeros, v;
    logic b, lost, cur;
    for (int i = 0; i < MAXN; i++) begin
      ev[i] = 0; ebit[i] = 0; eb[i] = 0; ef[i] = 0; el[i] = 0;
    end
    k = 0;
    while (k < n) begin
      if (rs(k)) begin
        t0 = k; zeros = 0; s = t0; lost = 0;
        while (!lost && s < n) begin
          cnt = 0;
          for (int j = s; j < s + L; j++) begin
            if (j < n && rs(j)) cnt++;
            if (j < n && j != t0) ef[j] = 1'b1;
          end
          v     = s + L;
          b     = (cnt >= TH);
          zeros = b ? 0 : zeros + 1;
          lost  = (zeros == MZ);
          if (v < n) begin
            ev[v] = 1'b1; ebit[v] = b; el[v] = lost;
          end
          s = v;
        end
        k = s;
      end else begin
        k++;
      end
    end
    cur = 1'b0;
    for (int i = 0; i < MAXN; i++) begin
      if (ev[i]) cur = ebit[i];
      eb[i] = cur;
    end
  endtask

  task automatic run_stream(input int n, input string tag);
    model(n);
    reset = 1'b0;
    y     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(tag, "rst_valid", 0, bit_valid, 1'b0);
    chk(tag, "rst_bit", 0, bit_out, 1'b0);
    chk(tag, "rst_frame", 0, in_frame, 1'b0);
    chk(tag, "rst_lost", 0, carrier_lost, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    y     = ys[0];
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      y = ys[k+1];
      @(negedge clk);
      ov[k] = bit_valid; ob[k] = bit_out; of_[k] = in_frame; ol[k] = carrier_lost;
      chk(tag, "valid", k, bit_valid, ev[k]);
      chk(tag, "bit", k, bit_out, eb[k]);
      chk(tag, "frame", k, in_frame, ef[k]);
      chk(tag, "lost", k, carrier_lost, el[k]);
    end
  endtask

  task automatic gen_random(input int n);
    int i, len, per, ph, kind;
    clear_ys();
    i = 0;
    while (i < n) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        i += int'($urandom_range(1, 70));
      end else if (kind == 3) begin
        ys[i] = 1'b1;
        i += 1 + int'($urandom_range(1, 6));
      end else begin
        len = int'($urandom_range(8, 90));
        per = 4 * int'($urandom_range(1, 3));
        ph  = int'($urandom_range(0, 3));
        for (int j = 0; j < len && i + j < n; j++)
          ys[i+j] = (((j + ph) % per) < per / 2);
        i += len;
      end
    end
  endtask

  initial begin
    int t0, t1, t2, n, v, cnt;
    reset = 1'b0;
    y     = 1'b0;

    tbl[0] = '{4, 1'b1}; tbl[1] = '{0, 1'b0}; tbl[2] = '{4, 1'b1}; tbl[3] = '{4, 1'b1};
    tbl[4] = '{1, 1'b0}; tbl[5] = '{2, 1'b1}; tbl[6] = '{3, 1'b1}; tbl[7] = '{4, 1'b1};

    // Idle line: nothing may happen.
    clear_ys();
    run_stream(200, "idle");

    // Continuous period-4 carrier for four symbols.
    clear_ys();
    t0 = 5;
    for (int j = t0; j < t0 + 4*L + 8; j++) ys[j] = (((j - t0) % 4) < 2);
    run_stream(t0 + 4*L + 4, "cont");
    chk("cont", "frame_t0", t0, of_[t0], 1'b0);
    chk("cont", "frame_t0p1", t0 + 1, of_[t0+1], 1'b1);
    for (int w = 1; w <= 4; w++) begin
      chk("cont", "valid_w", t0 + w*L, ov[t0 + w*L], 1'b1);
      chk("cont", "bit_w", t0 + w*L, ob[t0 + w*L], 1'b1);
    end

    // Table: pattern 1,0,1,1 then threshold windows of 1, 2, 3 edges.
    clear_ys();
    t0 = 5;
    for (int i = 0; i < 8; i++) put_pulses(t0 + i*L, tbl[i].nrise);
    run_stream(t0 + 8*L + 4, "tbl");
    for (int i = 0; i < 8; i++) begin
      v = t0 + (i + 1)*L;
      chk("tbl", "valid", v, ov[v], 1'b1);
      chk("tbl", "bit", v, ob[v], tbl[i].exp_bit);
      chk("tbl", "lost", v, ol[v], 1'b0);
    end

    // Carrier loss after one '1' symbol, then re-acquisition.
    clear_ys();
    t0 = 5;
    t1 = t0 + 90;
    put_pulses(t0, 4);
    put_pulses(t1, 4);
    put_pulses(t1 + L, 4);
    run_stream(t1 + 2*L + 4, "loss");
    chk("loss", "bit_1", t0 + L, ob[t0 + L], 1'b1);
    for (int w = 2; w <= 5; w++) begin
      chk("loss", "valid_0", t0 + w*L, ov[t0 + w*L], 1'b1);
      chk("loss", "bit_0", t0 + w*L, ob[t0 + w*L], 1'b0);
    end
    chk("loss", "lost_early", t0 + 4*L, ol[t0 + 4*L], 1'b0);
    chk("loss", "lost_80", t0 + 5*L, ol[t0 + 5*L], 1'b1);
    chk("loss", "frame_80", t0 + 5*L, of_[t0 + 5*L], 1'b0);
    chk("loss", "valid_t1", t1 + L, ov[t1 + L], 1'b1);
    chk("loss", "bit_t1", t1 + L, ob[t1 + L], 1'b1);

    // Async reset mid-window while bit_out=1 and in_frame=1.
    clear_ys();
    t0 = 5;
    for (int j = t0; j < t0 + 3*L; j++) ys[j] = (((j - t0) % 4) < 2);
    run_stream(t0 + L + 8, "arst");
    chk("arst", "pre_bit", t0 + L + 7, ob[t0 + L + 7], 1'b1);
    chk("arst", "pre_frame", t0 + L + 7, of_[t0 + L + 7], 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst", "async_bit", 0, bit_out, 1'b0);
    chk("arst", "async_frame", 0, in_frame, 1'b0);
    chk("arst", "async_valid", 0, bit_valid, 1'b0);
    chk("arst", "async_lost", 0, carrier_lost, 1'b0);
    clear_ys();
    t2 = 7;
    for (int j = t2; j < t2 + 3*L; j++) ys[j] = (((j - t2) % 4) < 2);
    run_stream(t2 + 2*L + 4, "arst2");
    cnt = 0;
    for (int k = 0; k < t2 + L; k++) if (ov[k]) cnt++;
    chk("arst2", "no_early_valid", cnt, (cnt == 0), 1'b1);
    chk("arst2", "valid_t2", t2 + L, ov[t2 + L], 1'b1);

    // Randomized streams against the model.
    for (int r = 0; r < 12; r++) begin
      n = 500;
      gen_random(n + 2);
      run_stream(n, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
